// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
package clk_div_pkg;

   localparam int DIV_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   // Number of high cycles in an N-cycle period; odd ratios get the extra high cycle.
   function automatic logic [31:0] high_len(input logic [31:0] n);
      return n - (n >> 1);
   endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control/config handshake and divider outputs of clk_div_ctrl.
interface clk_div_if import clk_div_pkg::*; #(
   parameter int DIV_W = DIV_W_DEF
) ();

   logic             enable;
   logic             cfg_valid;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;
   logic             div_out;
   logic             tick;
   logic             running;
   logic [DIV_W-1:0] cur_div;

   modport master (
      output enable, cfg_valid, cfg_div,
      input  cfg_ready, cfg_err, div_out, tick, running, cur_div
   );

   modport slave (
      input  enable, cfg_valid, cfg_div,
      output cfg_ready, cfg_err, div_out, tick, running, cur_div
   );

endinterface

// File: rtl/clk_div_counter.sv
// Period counter: counts 0..cur_div-1 while running, flags the wrap and decodes tick/div_out.
module clk_div_counter import clk_div_pkg::*; #(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             run_i,
   input  logic [DIV_W-1:0] cur_div_i,
   output logic             wrap_o,
   output logic             tick_o,
   output logic             div_out_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   // Counter sits at 0 while stopped, so a start always begins a fresh period.
   always_comb begin
      wrap_o    = run_i && (cnt_q == cur_div_i - DIV_W'(1));
      cnt_d     = (run_i && !wrap_o) ? cnt_q + DIV_W'(1) : '0;
      tick_o    = run_i && (cnt_q == '0);
      div_out_o = run_i && (32'(cnt_q) < high_len(32'(cur_div_i)));
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider sequencer: start/stop at period boundaries and glitch-free ratio updates.
module clk_div_ctrl import clk_div_pkg::*; #(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DEF_DIV = 3
) (
   input  logic     clk_in,
   input  logic     reset,
   clk_div_if.slave bus
);

   state_t           state_q;
   logic [DIV_W-1:0] cur_div_q;
   logic [DIV_W-1:0] pend_div_q;
   logic             cfg_err_q;

   logic running;
   logic ready;
   logic wrap;
   logic xfer;
   logic legal;

   assign running = (state_q != IDLE);
   assign ready   = (state_q != PEND);
   assign xfer    = bus.cfg_valid && ready;
   assign legal   = (bus.cfg_div != '0);

   clk_div_counter #(.DIV_W(DIV_W)) u_counter (
      .clk_in    (clk_in),
      .reset     (reset),
      .run_i     (running),
      .cur_div_i (cur_div_q),
      .wrap_o    (wrap),
      .tick_o    (bus.tick),
      .div_out_o (bus.div_out)
   );

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_div_q  <= DIV_W'(DEF_DIV);
         pend_div_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         cfg_err_q <= xfer && !legal;
         case (state_q)
            IDLE: begin
               if (xfer && legal) cur_div_q <= bus.cfg_div;
               if (bus.enable) state_q <= RUN;
            end
            RUN: begin
               // A ratio accepted in a stopping wrap has no later wrap to wait for.
               if (xfer && legal) begin
                  if (wrap && !bus.enable) begin
                     cur_div_q <= bus.cfg_div;
                     state_q   <= IDLE;
                  end else begin
                     pend_div_q <= bus.cfg_div;
                     state_q    <= PEND;
                  end
               end else if (wrap && !bus.enable) begin
                  state_q <= IDLE;
               end
            end
            PEND: begin
               if (wrap) begin
                  cur_div_q <= pend_div_q;
                  state_q   <= bus.enable ? RUN : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cfg_ready = ready;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.running   = running;
   assign bus.cur_div   = cur_div_q;

endmodule
